// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_nic
// Purpose  : Network interface controller bridging a CPU register port to the
//            local port of a bidirectional ring router. One 64-bit packet
//            buffer per direction, each with a full flag, exposed as four
//            memory-mapped registers. All buses are big-endian [0:MSB].
// Revision : 1.0 - initial release
// ============================================================================
module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  input  logic                  net_polarity
);

  localparam logic [1:0] c_ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] c_ADDR_IN_STS  = 2'b01;
  localparam logic [1:0] c_ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] c_ADDR_OUT_STS = 2'b11;

  logic [0:DATA_WIDTH-1] r_in_buf;
  logic [0:DATA_WIDTH-1] r_out_buf;
  logic                  r_in_full;
  logic                  r_out_full;

  logic                  w_rd;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_send;
  logic                  w_recv;
  logic                  w_ri;
  logic [0:DATA_WIDTH-1] w_in_status;
  logic [0:DATA_WIDTH-1] w_out_status;

  // Access decode, handshakes and status words.
  always_comb begin
    w_rd   = nicEn & ~nicWrEn;
    // Pop only when something is held, so a stalled read pops exactly once.
    w_pop  = w_rd & (addr == c_ADDR_IN_BUF) & r_in_full;
    // A write into a full buffer is dropped even if it drains this cycle.
    w_wr   = nicEn & nicWrEn & (addr == c_ADDR_OUT_BUF) & ~r_out_full;
    // Inject only when the packet's VC differs from the router's phase.
    w_send = r_out_full & net_ro & (r_out_buf[0] != net_polarity);
    // Not ready while reset is held so the router never delivers into reset.
    w_ri   = ~r_in_full & ~reset;
    w_recv = net_si & w_ri;

    w_in_status                  = '0;
    w_in_status[DATA_WIDTH-1]    = r_in_full;
    w_out_status                 = '0;
    w_out_status[DATA_WIDTH-1]   = r_out_full;
  end

  // CPU read mux; zero whenever the port is not performing a read.
  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        c_ADDR_IN_BUF:  d_out = r_in_buf;
        c_ADDR_IN_STS:  d_out = w_in_status;
        c_ADDR_OUT_STS: d_out = w_out_status;
        default:        d_out = '0;
      endcase
    end
  end

  // Router-facing outputs.
  always_comb begin
    net_so = w_send;
    net_do = r_out_buf;
    net_ri = w_ri;
  end

  // Output channel: CPU fills the buffer, router drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_send) begin
      r_out_full <= 1'b0;
    end else if (w_wr) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end
  end

  // Input channel: router fills the buffer, CPU read of 00 pops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_recv) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_pop) begin
      r_in_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cardinal_nic
// Purpose  : Directed self-checking bench for cardinal_nic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_polarity;

  int n_checks;
  int n_fails;

  localparam logic [63:0] c_W   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_P   = 64'h8000_0000_0000_0055;
  localparam logic [63:0] c_A   = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] c_B   = 64'hBBBB_0000_0000_0000;
  localparam logic [63:0] c_D   = 64'hDEAD_BEEF_0000_0042;
  localparam logic [63:0] c_X   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] c_ONE = 64'h1;

  cardinal_nic #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    #1;
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_si = 1'b0; net_di = '0; net_polarity = 1'b0;

    // ---- reset with no traffic ----
    #2;
    chk("rst_ri_low", {63'd0, net_ri}, 64'd0);
    chk("rst_so_low", {63'd0, net_so}, 64'd0);
    chk("rst_do_zero", net_do, 64'd0);
    chk("rst_dout_zero", d_out, 64'd0);
    #10 reset = 1'b0;           // released at t=12, between edges
    #1;
    chk("post_rst_ri", {63'd0, net_ri}, 64'd1);
    chk("post_rst_so", {63'd0, net_so}, 64'd0);
    rd(2'b01); chk("post_rst_sts01", d_out, 64'd0);
    rd(2'b11); chk("post_rst_sts11", d_out, 64'd0);
    rd(2'b10); chk("rd10_zero", d_out, 64'd0);
    wr(2'b01, c_X); chk("dout_on_write", d_out, 64'd0);
    idle();

    // ---- basic injection ----
    net_polarity = 1'b1; net_ro = 1'b1;
    tick();
    wr(2'b10, c_W);
    chk("pre_write_so", {63'd0, net_so}, 64'd0);
    tick();
    rd(2'b11);
    chk("inj_sts11_full", d_out, c_ONE);
    chk("inj_so_high", {63'd0, net_so}, 64'd1);
    chk("inj_do", net_do, c_W);
    tick();
    chk("inj_so_done", {63'd0, net_so}, 64'd0);
    chk("inj_sts11_empty", d_out, 64'd0);
    idle();

    // ---- VC phase wait ----
    wr(2'b10, c_P);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("vc_wait_so", {63'd0, net_so}, 64'd0);
      tick();
    end
    rd(2'b11); chk("vc_wait_still_full", d_out, c_ONE);
    net_polarity = 1'b0;
    #1;
    chk("vc_flip_so", {63'd0, net_so}, 64'd1);
    chk("vc_flip_do", net_do, c_P);
    tick();
    chk("vc_done_so", {63'd0, net_so}, 64'd0);
    chk("vc_done_sts", d_out, 64'd0);
    idle();

    // ---- write while full is dropped ----
    net_ro = 1'b0; net_polarity = 1'b0;
    wr(2'b10, c_A);
    tick();
    wr(2'b10, c_B);
    tick();
    idle();
    chk("drop_do_A", net_do, c_A);
    chk("drop_so_blocked", {63'd0, net_so}, 64'd0);
    net_ro = 1'b1;
    #1;
    chk("drop_so_go", {63'd0, net_so}, 64'd1);
    chk("drop_do_still_A", net_do, c_A);
    tick();
    chk("drop_so_done", {63'd0, net_so}, 64'd0);
    net_ro = 1'b0;

    // ---- ejection ----
    net_si = 1'b1; net_di = c_D;
    #1;
    chk("ej_ri_ready", {63'd0, net_ri}, 64'd1);
    tick();
    net_di = c_X;               // second strobe while full must be ignored
    rd(2'b01);
    chk("ej_ri_low", {63'd0, net_ri}, 64'd0);
    chk("ej_sts01_full", d_out, c_ONE);
    tick();
    net_si = 1'b0; net_di = '0;
    rd(2'b00);
    chk("ej_rd00", d_out, c_D);
    chk("ej_ri_still_low", {63'd0, net_ri}, 64'd0);
    tick();                     // pop edge; read held (stall)
    chk("ej_ri_after_pop", {63'd0, net_ri}, 64'd1);
    chk("ej_rd00_repeat", d_out, c_D);
    tick();
    rd(2'b01);
    chk("ej_sts01_empty", d_out, 64'd0);
    chk("ej_ri_stays", {63'd0, net_ri}, 64'd1);
    idle();

    // ---- async reset with both buffers full ----
    net_ro = 1'b0; net_polarity = 1'b1;
    wr(2'b10, c_W);             // VC 0, polarity 1 -> legal once ro rises
    net_si = 1'b1; net_di = c_X;
    tick();
    net_si = 1'b0;
    idle();
    net_ro = 1'b1;
    #1;
    chk("prerst_so", {63'd0, net_so}, 64'd1);
    chk("prerst_ri", {63'd0, net_ri}, 64'd0);
    #1 reset = 1'b1;            // mid-cycle, no clock edge
    #1;
    chk("arst_so", {63'd0, net_so}, 64'd0);
    chk("arst_ri", {63'd0, net_ri}, 64'd0);
    chk("arst_do", net_do, 64'd0);
    rd(2'b01); chk("arst_sts01", d_out, 64'd0);
    rd(2'b11); chk("arst_sts11", d_out, 64'd0);
    idle();
    reset = 1'b0;
    #1;
    chk("rel_ri", {63'd0, net_ri}, 64'd1);
    chk("rel_so", {63'd0, net_so}, 64'd0);
    rd(2'b01); chk("rel_sts01", d_out, 64'd0);
    rd(2'b11); chk("rel_sts11", d_out, 64'd0);
    rd(2'b00); chk("rel_inbuf", d_out, 64'd0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller; the responder side of the CPU's NIC port (2-bit address, enable, write-enable, 64-bit data in each direction).
- Bridges that port to the local port of a bidirectional ring router.
- Holds one 64-bit packet buffer toward the router (output channel) and one from the router (input channel), each with a full flag.
- Both buffers are exposed to the CPU as four memory-mapped registers. All buses are big-endian, [0:MSB].

Parameters:
DATA_WIDTH, 64, packet/register width; bit 0 is the packet VC bit, bit DATA_WIDTH-1 is the status flag bit

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
addr  input  2  register select [0:1]
d_in  input  DATA_WIDTH  write data from CPU
d_out  output  DATA_WIDTH  read data to CPU
nicEn  input  1  access enable
nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn)
net_so  output  1  send strobe to router input channel
net_ro  input  1  router ready to accept
net_do  output  DATA_WIDTH  packet to router
net_si  input  1  send strobe from router output channel
net_ri  output  1  NIC ready to accept
net_di  input  DATA_WIDTH  packet from router
net_polarity  input  1  router VC phase

Behaviour:
- Reset (async, active-high) clears in_buf, out_buf, in_full and out_full to 0.
  - Outputs during and after reset: net_so=0, d_out=0, net_do=0.
  - net_ri is forced to 0 while reset is high and becomes 1 once reset is released.
- Register map:
  - 00: input channel buffer (read).
  - 01: input status (read).
  - 10: output channel buffer (write).
  - 11: output status (read).
  - A status word is all zeros except bit DATA_WIDTH-1, which holds the full flag.
- CPU read (nicEn=1, nicWrEn=0): d_out is combinational, same cycle.
  - 00 returns in_buf; 01 and 11 return the status words; 10 returns 0.
  - When nicEn=0 or nicWrEn=1, d_out=0.
- Input pop: a read of 00 while in_full=1 clears in_full at the next edge; in_buf is kept.
  - A read of 00 while empty returns stale in_buf and changes no state.
  - A read held over several cycles (CPU stall) pops only once, because in_full is already 0 after the first edge.
- CPU write (nicEn=1, nicWrEn=1, addr=10):
  - out_full=0: out_buf<=d_in and out_full<=1 at the edge.
  - out_full=1: write dropped, no state change. This holds even if the buffer drains in the same cycle; software must poll 11 first.
  - Writes to 00, 01 and 11 are ignored.
- Injection toward the router:
  - net_do = out_buf, always.
  - net_so = out_full & net_ro & (out_buf[0] != net_polarity), combinational.
  - Transfer occurs on an edge where net_so=1; out_full clears at that edge.
  - If the VC bit equals net_polarity, the NIC waits for the next phase; no timeout.
- Ejection from the router:
  - net_ri = ~in_full (0 during reset).
  - On an edge with net_si & net_ri: in_buf<=net_di and in_full<=1.
  - net_si while net_ri=0 is a router protocol violation; the NIC ignores it and keeps in_buf.
- Concurrency: the input and output paths are independent.
  - A CPU pop of 00 and a router delivery cannot coincide, since net_ri=0 while full.
  - A write to 10 and a drain in the same cycle: drain wins, write dropped (see above).
- Latency:
  - CPU write to net_so high: 1 cycle minimum.
  - Router delivery to status 01 reading full: 1 cycle.
  - Pop to net_ri high: 1 cycle.
- Reset mid-transfer aborts both buffers and discards contents; no partial packet is ever emitted.

Test Plan:
- Reset with no traffic: immediately after release, net_ri=1, net_so=0; reads of 01 and 11 return 64'h0.
- Write 64'h0123_4567_89AB_CDEF to 10 with net_polarity=1 and net_ro=1 -> status 11 reads 64'h1 for 1 cycle; net_so=1 with net_do=that word; at the next edge net_so=0 and 11 reads 0.
- Write packet with bit0=1, hold net_ro=1 and net_polarity=1 for 3 cycles -> net_so stays 0; flip net_polarity=0 -> net_so=1 in that cycle, transfer completes at that edge.
- Write A=64'hAAAA_0000_0000_0001 with net_ro=0, then write B=64'hBBBB... -> B dropped; raise net_ro with legal polarity -> net_do=A.
- Router drives net_si=1 with net_di=64'hDEAD_BEEF_0000_0042 -> net_ri=0 next cycle and 01 reads 64'h1; second net_si ignored with in_buf unchanged; CPU read of 00 returns 64'hDEAD_BEEF_0000_0042, then net_ri=1 and 01 reads 0; a repeat read of 00 returns the same word with no change.
- Assert reset asynchronously (mid-cycle) while both buffers are full -> net_so=0, net_ri=0 and in_full/out_full=0 immediately; after release net_ri=1 and status reads 0.
